hififo_ctrl_regs: RTL and testbench

Parametrised control/status register and interrupt block for the HIFIFO PCIe endpoint, serving NCH FIFO channels instead of a fixed two. Sits between pcie_rx/pcie_tx (PIO writes, read requests, read completion data) and the per-channel FIFO engines (status words, interrupt levels, reset lines). Adds interrupt coalescing with a request/acknowledge handshake and hold-off timer, and a minimum-width stretch for channel resets.

---
 rtl/hififo_ctrl_pkg.sv | 24 ++
 rtl/hififo_irq_gen.sv | 93 +++++++++
 rtl/hififo_ctrl_regs.sv | 126 ++++++++++++
 tb/tb_hififo_ctrl_regs.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hififo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hififo_ctrl_pkg
// Purpose  : Shared definitions for the HIFIFO control/status register block:
//            PIO register address map and the interrupt FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hififo_ctrl_pkg;

   localparam logic [10:0] ADDR_INT_STATUS     = 11'd0;
   localparam logic [10:0] ADDR_VERSION        = 11'd1;
   localparam logic [10:0] ADDR_INT_MASK       = 11'd2;
   localparam logic [10:0] ADDR_RESET_CTL      = 11'd3;
   localparam logic [10:0] ADDR_CH_STATUS_BASE = 11'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HOLDOFF = 2'd2
   } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/hififo_irq_gen.sv
`default_nettype none
// ============================================================================
// Module   : hififo_irq_gen
// Purpose  : Interrupt coalescing. Masked edges (both directions) of the
//            channel interrupt levels accumulate in a pending register; a
//            request/acknowledge FSM with a hold-off timer turns any number
//            of accumulated events into a single irq_req.
// Ports    : clock, reset_n      - clock, async active-low reset
//            ch_interrupt [NCH]  - channel interrupt levels
//            int_mask     [NCH]  - current interrupt mask register
//            mask_wr, mask_wdata - mask being written this cycle
//            irq_ack             - core accepted the request
//            irq_req             - registered interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module hififo_irq_gen
   import hififo_ctrl_pkg::*;
#(
   parameter int NCH            = 4,
   parameter int HOLDOFF_CYCLES = 64
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [NCH-1:0] ch_interrupt,
   input  logic [NCH-1:0] int_mask,
   input  logic           mask_wr,
   input  logic [NCH-1:0] mask_wdata,
   input  logic           irq_ack,
   output logic           irq_req
);

   // Counter holds at most HOLDOFF_CYCLES-1
   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   irq_state_t     state;
   logic [HW-1:0]  holdoff_cnt;
   logic [NCH-1:0] int_prev;
   logic [NCH-1:0] pending;
   logic [NCH-1:0] ev;
   logic [NCH-1:0] pending_next;

   assign ev = int_mask & (ch_interrupt ^ int_prev);

   // Leaving IDLE consumes the pending set, but events arriving in that
   // same cycle must still be kept for the next request.
   always_comb begin
      pending_next = pending | ev;
      if (state == IDLE && pending != '0)
         pending_next = ev;
      if (mask_wr)
         pending_next = pending_next & mask_wdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         holdoff_cnt <= '0;
         int_prev    <= '0;
         pending     <= '0;
         irq_req     <= 1'b0;
      end else begin
         int_prev <= ch_interrupt;
         pending  <= pending_next;
         case (state)
            IDLE: begin
               if (pending != '0) begin
                  state   <= REQ;
                  irq_req <= 1'b1;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  state       <= HOLDOFF;
                  irq_req     <= 1'b0;
                  holdoff_cnt <= HW'(HOLDOFF_CYCLES - 1);
               end
            end
            HOLDOFF: begin
               if (holdoff_cnt == '0)
                  state <= IDLE;
               else
                  holdoff_cnt <= holdoff_cnt - HW'(1);
            end
            default: begin
               state   <= IDLE;
               irq_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/hififo_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : hififo_ctrl_regs
// Purpose  : Control/status registers and interrupt block for NCH HIFIFO
//            channels: PIO register decode, read completions, read-to-clear
//            interrupt status, interrupt coalescing (hififo_irq_gen) and
//            minimum-width stretching of the channel reset lines.
// Ports    : clock, reset_n            - clock, async active-low reset
//            pio_wvalid/pio_rvalid     - PIO write / read strobes
//            pio_addr, pio_wdata       - dword index, write data ([31:0])
//            rc_done, rc_data          - read completion (1 cycle later)
//            ch_interrupt, ch_status   - per-channel inputs
//            ch_reset                  - per-channel FIFO reset
//            irq_req, irq_ack          - interrupt handshake to core
// Revision : 1.0 - initial release
// ============================================================================
module hififo_ctrl_regs
   import hififo_ctrl_pkg::*;
#(
   parameter int          NCH            = 4,
   parameter logic [31:0] VERSION        = 32'h0000_0102,
   parameter int          HOLDOFF_CYCLES = 64,
   parameter int          RESET_CYCLES   = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              pio_wvalid,
   input  logic              pio_rvalid,
   input  logic [10:0]       pio_addr,
   input  logic [63:0]       pio_wdata,
   output logic              rc_done,
   output logic [31:0]       rc_data,
   input  logic [NCH-1:0]    ch_interrupt,
   input  logic [32*NCH-1:0] ch_status,
   output logic [NCH-1:0]    ch_reset,
   output logic              irq_req,
   input  logic              irq_ack
);

   localparam int RW = $clog2(RESET_CYCLES + 1);

   logic [NCH-1:0] int_status;
   logic [NCH-1:0] int_mask;
   logic [NCH-1:0] reset_ctl;
   logic [31:0]    rd_value;
   logic           wr_mask;
   logic           wr_reset;
   logic           rd_clear;
   logic           unused_wdata;

   assign wr_mask      = pio_wvalid && (pio_addr == ADDR_INT_MASK);
   assign wr_reset     = pio_wvalid && (pio_addr == ADDR_RESET_CTL);
   assign rd_clear     = pio_rvalid && (pio_addr == ADDR_INT_STATUS);
   assign unused_wdata = ^pio_wdata[63:NCH];

   // Read mux sees register values before any same-cycle write lands.
   always_comb begin
      rd_value = '0;
      if (pio_addr == ADDR_INT_STATUS)
         rd_value[NCH-1:0] = int_status;
      else if (pio_addr == ADDR_VERSION)
         rd_value = VERSION;
      else if (pio_addr == ADDR_INT_MASK)
         rd_value[NCH-1:0] = int_mask;
      else if (pio_addr == ADDR_RESET_CTL)
         rd_value[NCH-1:0] = reset_ctl;
      else begin
         for (int k = 0; k < NCH; k++)
            if (pio_addr == ADDR_CH_STATUS_BASE + 11'(k))
               rd_value = ch_status[32*k +: 32];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rc_done    <= 1'b0;
         rc_data    <= '0;
         int_status <= '0;
         int_mask   <= '0;
         reset_ctl  <= '1;
      end else begin
         rc_done <= pio_rvalid;
         if (pio_rvalid)
            rc_data <= rd_value;
         // A level rising in the clearing cycle is kept.
         int_status <= (rd_clear ? '0 : int_status) | ch_interrupt;
         if (wr_mask)
            int_mask <= pio_wdata[NCH-1:0];
         if (wr_reset)
            reset_ctl <= pio_wdata[NCH-1:0];
      end
   end

   // Writing 1 starts a minimum-width window; the line stays high until
   // both the control bit is cleared and the window has expired.
   generate
      for (genvar k = 0; k < NCH; k++) begin : g_stretch
         logic [RW-1:0] stretch_cnt;
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
               stretch_cnt <= '0;
            else if (wr_reset && pio_wdata[k])
               stretch_cnt <= RW'(RESET_CYCLES);
            else if (stretch_cnt != '0)
               stretch_cnt <= stretch_cnt - RW'(1);
         end
         assign ch_reset[k] = reset_ctl[k] | (stretch_cnt != '0);
      end
   endgenerate

   hififo_irq_gen #(
      .NCH            (NCH),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
   ) u_irq_gen (
      .clock        (clock),
      .reset_n      (reset_n),
      .ch_interrupt (ch_interrupt),
      .int_mask     (int_mask),
      .mask_wr      (wr_mask),
      .mask_wdata   (pio_wdata[NCH-1:0]),
      .irq_ack      (irq_ack),
      .irq_req      (irq_req)
   );

endmodule
`default_nettype wire

// File: tb/tb_hififo_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_hififo_ctrl_regs
// Purpose  : Directed self-checking bench for hififo_ctrl_regs (NCH=4,
//            HOLDOFF_CYCLES=64, RESET_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hififo_ctrl_regs;

   localparam int NCH = 4;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           pio_wvalid;
   logic           pio_rvalid;
   logic [10:0]    pio_addr;
   logic [63:0]    pio_wdata;
   logic           rc_done;
   logic [31:0]    rc_data;
   logic [NCH-1:0] ch_interrupt;
   logic [127:0]   ch_status;
   logic [NCH-1:0] ch_reset;
   logic           irq_req;
   logic           irq_ack;

   int n_checks = 0;
   int n_pass   = 0;

   hififo_ctrl_regs #(
      .NCH            (NCH),
      .VERSION        (32'h0000_0102),
      .HOLDOFF_CYCLES (64),
      .RESET_CYCLES   (16)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .pio_wvalid   (pio_wvalid),
      .pio_rvalid   (pio_rvalid),
      .pio_addr     (pio_addr),
      .pio_wdata    (pio_wdata),
      .rc_done      (rc_done),
      .rc_data      (rc_data),
      .ch_interrupt (ch_interrupt),
      .ch_status    (ch_status),
      .ch_reset     (ch_reset),
      .irq_req      (irq_req),
      .irq_ack      (irq_ack)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pio_write(input logic [10:0] addr, input logic [31:0] data);
      pio_addr   = addr;
      pio_wdata  = {32'h0, data};
      pio_wvalid = 1'b1;
      tick();
      pio_wvalid = 1'b0;
   endtask

   task automatic pio_read(input logic [10:0] addr, output logic [31:0] data);
      pio_addr   = addr;
      pio_rvalid = 1'b1;
      tick();
      pio_rvalid = 1'b0;
      check("rc_done_pulse", {31'b0, rc_done}, 32'd1);
      data = rc_data;
      tick();
      check("rc_done_low", {31'b0, rc_done}, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        seen;
      logic        held;
      int          high_cycles;

      reset_n      = 1'b0;
      pio_wvalid   = 1'b0;
      pio_rvalid   = 1'b0;
      pio_addr     = '0;
      pio_wdata    = '0;
      irq_ack      = 1'b0;
      ch_interrupt = '0;
      ch_status    = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

      // Reset state
      repeat (3) tick();
      check("rst_irq_req", {31'b0, irq_req}, 32'd0);
      check("rst_rc_done", {31'b0, rc_done}, 32'd0);
      check("rst_rc_data", rc_data, 32'd0);
      check("rst_ch_reset", {28'b0, ch_reset}, 32'hF);
      reset_n = 1'b1;
      tick();

      // Version, then release channel resets without a prior 1-write
      pio_read(11'd1, rd);
      check("version", rd, 32'h0000_0102);
      check("ch_reset_held", {28'b0, ch_reset}, 32'hF);
      pio_write(11'd3, 32'h0);
      check("ch_reset_release", {28'b0, ch_reset}, 32'h0);

      // Masked edge on channel 0 -> irq_req two cycles later
      pio_write(11'd2, 32'h5);
      ch_interrupt[0] = 1'b1;
      tick();
      check("irq_not_yet", {31'b0, irq_req}, 32'd0);
      tick();
      check("irq_rise", {31'b0, irq_req}, 32'd1);
      held = 1'b1;
      repeat (10) begin
         tick();
         held &= irq_req;
      end
      check("irq_held_no_ack", {31'b0, held}, 32'd1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("irq_drop_on_ack", {31'b0, irq_req}, 32'd0);

      // Three toggles of ch2 plus masked ch1 during hold-off -> one request
      ch_interrupt[2] = 1'b1;
      ch_interrupt[1] = 1'b1;
      tick();
      ch_interrupt[2] = 1'b0;
      tick();
      ch_interrupt[2] = 1'b1;
      tick();
      seen = 1'b0;
      for (int i = 4; i <= 64; i++) begin
         tick();
         seen |= irq_req;
      end
      check("holdoff_quiet", {31'b0, seen}, 32'd0);
      tick();
      check("holdoff_rerequest", {31'b0, irq_req}, 32'd1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("rerequest_ack", {31'b0, irq_req}, 32'd0);
      seen = 1'b0;
      repeat (100) begin
         tick();
         seen |= irq_req;
      end
      check("single_rerequest", {31'b0, seen}, 32'd0);

      // Mask readback, then read-to-clear status
      pio_read(11'd2, rd);
      check("mask_read", rd, 32'h5);
      pio_write(11'd2, 32'h0);
      ch_interrupt = '0;
      tick();
      pio_read(11'd0, rd);
      check("status_latched", rd, 32'h7);
      ch_interrupt[3] = 1'b1;
      tick();
      pio_read(11'd0, rd);
      check("status_level_1", rd, 32'h8);
      pio_read(11'd0, rd);
      check("status_level_2", rd, 32'h8);
      ch_interrupt[3] = 1'b0;
      pio_read(11'd0, rd);
      check("status_after_drop", rd, 32'h8);
      pio_read(11'd0, rd);
      check("status_cleared", rd, 32'h0);

      // Simultaneous write and read return the pre-write value
      pio_addr   = 11'd2;
      pio_wdata  = 64'h3;
      pio_wvalid = 1'b1;
      pio_rvalid = 1'b1;
      tick();
      pio_wvalid = 1'b0;
      pio_rvalid = 1'b0;
      check("rw_same_cycle", rc_data, 32'h0);
      tick();
      pio_read(11'd2, rd);
      check("rw_write_landed", rd, 32'h3);

      // Reset stretch: 1-write then 0-write keeps ch_reset[0] high 16 cycles
      pio_write(11'd3, 32'h1);
      check("stretch_start", {28'b0, ch_reset}, 32'h1);
      pio_write(11'd3, 32'h0);
      high_cycles = 2;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ch_reset[0])
            high_cycles++;
         else
            break;
      end
      check("stretch_width", 32'(high_cycles), 32'd16);

      // Channel status window and unmapped addresses
      pio_read(11'd5, rd);
      check("ch_status_1", rd, 32'hC0DE_0001);
      pio_read(11'd8, rd);
      check("past_ch_status", rd, 32'h0);
      pio_read(11'h7FF, rd);
      check("unmapped", rd, 32'h0);

      // Asynchronous reset during an outstanding request
      pio_write(11'd2, 32'h1);
      ch_interrupt[0] = 1'b1;
      tick();
      tick();
      check("req_before_reset", {31'b0, irq_req}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_irq_drop", {31'b0, irq_req}, 32'd0);
      check("async_ch_reset", {28'b0, ch_reset}, 32'hF);
      tick();
      reset_n = 1'b1;
      ch_interrupt = '0;
      tick();
      pio_read(11'd2, rd);
      check("mask_after_reset", rd, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
